decode_stage: RTL and testbench
===============================

# decode_stage

Pipeline decode stage of the LC-3 datapath, sitting between Fetch and Execute. It latches the fetched instruction and next PC, and decodes the opcode into Execute, Memory and Writeback control fields. It also owns the 8×16 general-purpose register file: it reads source operands into the 48-bit operand bundle consumed by Execute, and accepts register writes from Writeback.

## Interface
Parameters: none.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- enable_decode  in  1  stage advance; outputs update only when high
- dout  in  16  instruction word from Fetch
- npc_in  in  16  PC+1 from Fetch
- W_en  in  1  register-file write enable from Writeback
- W_addr  in  3  register-file write address
- W_data  in  16  register-file write data
- D_Data  out  48  {IR, VSR1, VSR2} to Execute
- E_Control  out  6  Execute control field
- npc_out  out  16  latched npc_in
- W_Control  out  2  writeback source: 00 ALU, 01 address unit, 10 memory
- Mem_Control  out  3  {indirect, write, read}
- reg_write  out  1  instruction writes a destination register
- dest  out  3  destination register
- illegal  out  1  latched opcode is unsupported

## Operation
**Register file**
- 8 entries, R0–R7, all cleared on reset.
- Written at the clock edge when W_en is high.

**Decode (on a rising edge with enable_decode high)**
- IR, npc_out and every control output are registered from dout, npc_in and the decode below.
- VSR1 = R[dout[8:6]].
- VSR2 = R[dout[11:9]] for ST, STR and STI; otherwise R[dout[2:0]].
- Bypass: if W_en is high and W_addr equals a source address in the same cycle, that source takes W_data.
- With enable_decode low, all outputs hold. Register-file writes still occur.

**E_Control encoding**
- [5:3] selects the ALU operation: 000 ADD reg, 001 ADD imm, 010 AND reg, 011 AND imm, 100 NOT.
- [2:1] selects the offset: 00 offset11, 01 offset9, 10 offset6, 11 none.
- [0] selects the address base: 0 VSR1, 1 npc.
- The imm bit is dout[5] for ADD and AND.

**Per-opcode decode** (fields listed are E_Control / W_Control / Mem_Control / reg_write; dest = dout[11:9] when reg_write is 1, else 0)
- ADD (0001), AND (0101): ALU code as above with [2:0] = 000 / 00 / 000 / 1.
- NOT (1001): 100000 / 00 / 000 / 1.
- BR (0000): 000011 / 00 / 000 / 0.
- JMP (1100): 000110 / 00 / 000 / 0.
- LD (0010): 000011 / 10 / 001 / 1.
- LDI (1010): 000011 / 10 / 101 / 1.
- LDR (0110): 000100 / 10 / 001 / 1.
- LEA (1110): 000011 / 01 / 000 / 1.
- ST (0011): 000011 / 00 / 010 / 0.
- STI (1011): 000011 / 00 / 110 / 0.
- STR (0111): 000100 / 00 / 010 / 0.
- Any other opcode (JSR, RTI, TRAP, reserved): all controls 0, reg_write 0, dest 0, illegal 1. IR is still latched.
- illegal is 0 for every supported opcode.

## Timing
- Latency: exactly one cycle from dout/npc_in to all outputs.
- Reset has priority over enable_decode and W_en.
- Reset value of every output is 0, and the register file is cleared.
- A write and an operand read of the same register in the same cycle returns the new value through the bypass.
- If two instructions are decoded back-to-back, a write landing in the second decode cycle is bypassed for that cycle only.
- An instruction is decoded only on an enable_decode edge. The stage performs no self-advance.
- A reset asserted mid-stream clears state on that edge. The first decode after reset deasserts uses the reset register values (all 0) unless bypassed.

## Test plan
- **Reset:** reset=1 for 2 cycles → D_Data=0, E_Control=0, npc_out=0, W_Control=0, Mem_Control=0, reg_write=0, dest=0, illegal=0; reading R0–R7 yields 0.
- **Write then ADD imm:** write R1=0x0005; then dout=0x1262, npc_in=0x3001, enable_decode=1 → IR=0x1262, VSR1=0x0005, E_Control=6'b001000, W_Control=00, reg_write=1, dest=1, npc_out=0x3001.
- **STR with bypass:** R2=0x4000 written earlier; W_en=1, W_addr=3, W_data=0xBEEF in the same cycle as dout=0x76BF → VSR1=0x4000, VSR2=0xBEEF, E_Control=6'b000100, Mem_Control=010, reg_write=0.
- **Hold:** decode LDI 0xA0FF, then enable_decode=0 while dout changes for 3 cycles → outputs stay E_Control=000011, Mem_Control=101, W_Control=10, dest=0.
- **Illegal:** dout=0xF025 → IR=0xF025, illegal=1, all controls 0.
- **Reset mid-stream:** decode NOT 0x9A7F, then assert reset → next edge all outputs 0 and R0–R7 cleared.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : LC-3 decode stage. Latches IR/NPC, decodes control fields and
//            reads operands from the 8x16 register file with write bypass.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    input  logic        W_en,
    input  logic [2:0]  W_addr,
    input  logic [15:0] W_data,
    output logic [47:0] D_Data,
    output logic [5:0]  E_Control,
    output logic [15:0] npc_out,
    output logic [1:0]  W_Control,
    output logic [2:0]  Mem_Control,
    output logic        reg_write,
    output logic [2:0]  dest,
    output logic        illegal
);

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;

    localparam logic [1:0] c_WB_ALU  = 2'b00;
    localparam logic [1:0] c_WB_ADDR = 2'b01;
    localparam logic [1:0] c_WB_MEM  = 2'b10;

    localparam logic [2:0] c_MEM_NONE  = 3'b000;
    localparam logic [2:0] c_MEM_READ  = 3'b001;
    localparam logic [2:0] c_MEM_WRITE = 3'b010;
    localparam logic [2:0] c_MEM_RIND  = 3'b101;
    localparam logic [2:0] c_MEM_WIND  = 3'b110;

    logic [15:0] regs_q [8];

    logic [47:0] d_data_q;
    logic [5:0]  e_ctrl_q;
    logic [15:0] npc_q;
    logic [1:0]  w_ctrl_q;
    logic [2:0]  mem_ctrl_q;
    logic        reg_write_q;
    logic [2:0]  dest_q;
    logic        illegal_q;

    logic [3:0]  opcode;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [15:0] vsr1;
    logic [15:0] vsr2;

    logic [5:0]  e_ctrl_d;
    logic [1:0]  w_ctrl_d;
    logic [2:0]  mem_ctrl_d;
    logic        reg_write_d;
    logic [2:0]  dest_d;
    logic        illegal_d;
    logic        store_op;

    assign opcode   = dout[15:12];
    assign store_op = (opcode == c_OP_ST) || (opcode == c_OP_STR) || (opcode == c_OP_STI);
    assign sr1_addr = dout[8:6];
    // Stores carry their data register in the DR field rather than SR2.
    assign sr2_addr = store_op ? dout[11:9] : dout[2:0];

    // Same-cycle writeback is forwarded so the decoded operand is never stale.
    assign vsr1 = (W_en && (W_addr == sr1_addr)) ? W_data : regs_q[sr1_addr];
    assign vsr2 = (W_en && (W_addr == sr2_addr)) ? W_data : regs_q[sr2_addr];

    always_comb begin
        e_ctrl_d    = 6'b000000;
        w_ctrl_d    = c_WB_ALU;
        mem_ctrl_d  = c_MEM_NONE;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                e_ctrl_d    = {2'b00, dout[5], 3'b000};
                reg_write_d = 1'b1;
            end
            c_OP_AND: begin
                e_ctrl_d    = {2'b01, dout[5], 3'b000};
                reg_write_d = 1'b1;
            end
            c_OP_NOT: begin
                e_ctrl_d    = 6'b100000;
                reg_write_d = 1'b1;
            end
            c_OP_BR: begin
                e_ctrl_d = 6'b000011;
            end
            c_OP_JMP: begin
                e_ctrl_d = 6'b000110;
            end
            c_OP_LD: begin
                e_ctrl_d    = 6'b000011;
                w_ctrl_d    = c_WB_MEM;
                mem_ctrl_d  = c_MEM_READ;
                reg_write_d = 1'b1;
            end
            c_OP_LDI: begin
                e_ctrl_d    = 6'b000011;
                w_ctrl_d    = c_WB_MEM;
                mem_ctrl_d  = c_MEM_RIND;
                reg_write_d = 1'b1;
            end
            c_OP_LDR: begin
                e_ctrl_d    = 6'b000100;
                w_ctrl_d    = c_WB_MEM;
                mem_ctrl_d  = c_MEM_READ;
                reg_write_d = 1'b1;
            end
            c_OP_LEA: begin
                e_ctrl_d    = 6'b000011;
                w_ctrl_d    = c_WB_ADDR;
                reg_write_d = 1'b1;
            end
            c_OP_ST: begin
                e_ctrl_d   = 6'b000011;
                mem_ctrl_d = c_MEM_WRITE;
            end
            c_OP_STI: begin
                e_ctrl_d   = 6'b000011;
                mem_ctrl_d = c_MEM_WIND;
            end
            c_OP_STR: begin
                e_ctrl_d   = 6'b000100;
                mem_ctrl_d = c_MEM_WRITE;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
        dest_d = reg_write_d ? dout[11:9] : 3'b000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (W_en) begin
            regs_q[W_addr] <= W_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_data_q    <= 48'h0;
            e_ctrl_q    <= 6'b000000;
            npc_q       <= 16'h0000;
            w_ctrl_q    <= 2'b00;
            mem_ctrl_q  <= 3'b000;
            reg_write_q <= 1'b0;
            dest_q      <= 3'b000;
            illegal_q   <= 1'b0;
        end else if (enable_decode) begin
            d_data_q    <= {dout, vsr1, vsr2};
            e_ctrl_q    <= e_ctrl_d;
            npc_q       <= npc_in;
            w_ctrl_q    <= w_ctrl_d;
            mem_ctrl_q  <= mem_ctrl_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            illegal_q   <= illegal_d;
        end
    end

    assign D_Data      = d_data_q;
    assign E_Control   = e_ctrl_q;
    assign npc_out     = npc_q;
    assign W_Control   = w_ctrl_q;
    assign Mem_Control = mem_ctrl_q;
    assign reg_write   = reg_write_q;
    assign dest        = dest_q;
    assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed table-driven bench for decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic        W_en;
    logic [2:0]  W_addr;
    logic [15:0] W_data;
    logic [47:0] D_Data;
    logic [5:0]  E_Control;
    logic [15:0] npc_out;
    logic [1:0]  W_Control;
    logic [2:0]  Mem_Control;
    logic        reg_write;
    logic [2:0]  dest;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .W_en          (W_en),
        .W_addr        (W_addr),
        .W_data        (W_data),
        .D_Data        (D_Data),
        .E_Control     (E_Control),
        .npc_out       (npc_out),
        .W_Control     (W_Control),
        .Mem_Control   (Mem_Control),
        .reg_write     (reg_write),
        .dest          (dest),
        .illegal       (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] din;
        logic [15:0] npc;
        logic        wen;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [47:0] dd;
        logic [5:0]  ec;
        logic [1:0]  wc;
        logic [2:0]  mc;
        logic        rw;
        logic [2:0]  dst;
        logic        ill;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic en, input logic [15:0] d, input logic [15:0] n,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd);
        enable_decode = en;
        dout          = d;
        npc_in        = n;
        W_en          = we;
        W_addr        = wa;
        W_data        = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " D_Data"},      D_Data,      48'h0);
        chk({tag, " E_Control"},   E_Control,   48'h0);
        chk({tag, " npc_out"},     npc_out,     48'h0);
        chk({tag, " W_Control"},   W_Control,   48'h0);
        chk({tag, " Mem_Control"}, Mem_Control, 48'h0);
        chk({tag, " reg_write"},   reg_write,   48'h0);
        chk({tag, " dest"},        dest,        48'h0);
        chk({tag, " illegal"},     illegal,     48'h0);
    endtask

    // ADD Ri, Ri, Ri exposes Ri on both operand slots.
    task automatic chk_regs_zero(input string tag);
        logic [2:0] r;
        for (int i = 0; i < 8; i++) begin
            r = 3'(i);
            cycle(1'b1, {4'b0001, r, r, 3'b000, r}, 16'h0000, 1'b0, 3'd0, 16'h0);
            chk($sformatf("%s R%0d", tag, i), D_Data[31:0], 48'h0);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 16'h3000, 1'b1, 3'd1, 16'h0005, 48'h0000_0000_0000, 6'b000011, 2'b00, 3'b000, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{16'h1262, 16'h3001, 1'b1, 3'd2, 16'h4000, 48'h1262_0005_4000, 6'b001000, 2'b00, 3'b000, 1'b1, 3'd1, 1'b0};
        vecs[2]  = '{16'h76BF, 16'h3002, 1'b1, 3'd3, 16'hBEEF, 48'h76BF_4000_BEEF, 6'b000100, 2'b00, 3'b010, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{16'h5042, 16'h3003, 1'b0, 3'd0, 16'h0000, 48'h5042_0005_4000, 6'b010000, 2'b00, 3'b000, 1'b1, 3'd0, 1'b0};
        vecs[4]  = '{16'h5A7F, 16'h3004, 1'b0, 3'd0, 16'h0000, 48'h5A7F_0005_0000, 6'b011000, 2'b00, 3'b000, 1'b1, 3'd5, 1'b0};
        vecs[5]  = '{16'h2403, 16'h3005, 1'b0, 3'd0, 16'h0000, 48'h2403_0000_BEEF, 6'b000011, 2'b10, 3'b001, 1'b1, 3'd2, 1'b0};
        vecs[6]  = '{16'h6681, 16'h3006, 1'b0, 3'd0, 16'h0000, 48'h6681_4000_0005, 6'b000100, 2'b10, 3'b001, 1'b1, 3'd3, 1'b0};
        vecs[7]  = '{16'hE9FF, 16'h3007, 1'b0, 3'd0, 16'h0000, 48'hE9FF_0000_0000, 6'b000011, 2'b01, 3'b000, 1'b1, 3'd4, 1'b0};
        vecs[8]  = '{16'h3601, 16'h3008, 1'b0, 3'd0, 16'h0000, 48'h3601_0000_BEEF, 6'b000011, 2'b00, 3'b010, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{16'hB280, 16'h3009, 1'b0, 3'd0, 16'h0000, 48'hB280_4000_0005, 6'b000011, 2'b00, 3'b110, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{16'hC1C0, 16'h300A, 1'b1, 3'd7, 16'h1234, 48'hC1C0_1234_0000, 6'b000110, 2'b00, 3'b000, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{16'hF025, 16'h300B, 1'b0, 3'd0, 16'h0000, 48'hF025_0000_0000, 6'b000000, 2'b00, 3'b000, 1'b0, 3'd0, 1'b1};
        vecs[12] = '{16'h9A7F, 16'h300C, 1'b0, 3'd0, 16'h0000, 48'h9A7F_0005_1234, 6'b100000, 2'b00, 3'b000, 1'b1, 3'd5, 1'b0};
        vecs[13] = '{16'h4800, 16'h300D, 1'b0, 3'd0, 16'h0000, 48'h4800_0000_0000, 6'b000000, 2'b00, 3'b000, 1'b0, 3'd0, 1'b1};

        reset = 1'b1;
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0);
        chk_all_zero("reset");
        reset = 1'b0;
        chk_regs_zero("reset_rf");

        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, vecs[i].din, vecs[i].npc, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            chk($sformatf("v%0d D_Data", i),      D_Data,      vecs[i].dd);
            chk($sformatf("v%0d E_Control", i),   E_Control,   48'(vecs[i].ec));
            chk($sformatf("v%0d npc_out", i),     npc_out,     48'(vecs[i].npc));
            chk($sformatf("v%0d W_Control", i),   W_Control,   48'(vecs[i].wc));
            chk($sformatf("v%0d Mem_Control", i), Mem_Control, 48'(vecs[i].mc));
            chk($sformatf("v%0d reg_write", i),   reg_write,   48'(vecs[i].rw));
            chk($sformatf("v%0d dest", i),        dest,        48'(vecs[i].dst));
            chk($sformatf("v%0d illegal", i),     illegal,     48'(vecs[i].ill));
        end

        // Hold: outputs frozen while dout wiggles; register write still lands.
        cycle(1'b1, 16'hA0FF, 16'h3100, 1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 16'h1000 + 16'(k * 16'h1111), 16'h4000 + 16'(k), (k == 0), 3'd5, 16'h0777);
            chk($sformatf("hold%0d IR", k),          D_Data[47:32], 48'hA0FF);
            chk($sformatf("hold%0d E_Control", k),   E_Control,     48'b000011);
            chk($sformatf("hold%0d Mem_Control", k), Mem_Control,   48'b101);
            chk($sformatf("hold%0d W_Control", k),   W_Control,     48'b10);
            chk($sformatf("hold%0d reg_write", k),   reg_write,     48'h1);
            chk($sformatf("hold%0d dest", k),        dest,          48'h0);
            chk($sformatf("hold%0d npc_out", k),     npc_out,       48'h3100);
        end
        cycle(1'b1, 16'h1145, 16'h3101, 1'b0, 3'd0, 16'h0);
        chk("hold_write D_Data", D_Data, 48'h1145_0777_0777);

        // Reset mid-stream wins over a pending decode and a register write.
        cycle(1'b1, 16'h9A7F, 16'h3200, 1'b0, 3'd0, 16'h0);
        chk("pre_reset reg_write", reg_write, 48'h1);
        chk("pre_reset dest",      dest,      48'h5);
        reset = 1'b1;
        cycle(1'b1, 16'h1262, 16'h3201, 1'b1, 3'd1, 16'hFFFF);
        chk_all_zero("midreset");
        reset = 1'b0;
        chk_regs_zero("midreset_rf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
